m_pipe_ctrl: RTL and testbench



---
 rtl/m_pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_m_pipe_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_pipe_ctrl.sv
// m_pipe_ctrl: control sequencer for the 3-stage RV32I pipeline (IF / ID / EX+MA+WB).
// Owns the stage valid bits, PC/P1 write enables, P1/P2 bubble injection,
// EX->ID bypass selects, the start/halt/drain FSM and the performance counters.
module m_pipe_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             w_clock,
    input  logic             w_rst_n,
    input  logic             w_start,
    input  logic             w_stall_req,
    input  logic [4:0]       w_id_rs1,
    input  logic [4:0]       w_id_rs2,
    input  logic             w_id_use_rs2,
    input  logic             w_id_halt,
    input  logic [4:0]       w_ex_rd,
    input  logic             w_ex_wen,
    input  logic             w_ex_taken,
    output logic             w_pc_we,
    output logic             w_p1_we,
    output logic             w_p1_flush,
    output logic             w_p2_flush,
    output logic             w_fwd1,
    output logic             w_fwd2,
    output logic             w_running,
    output logic             w_done,
    output logic [CNT_W-1:0] w_cycles,
    output logic [CNT_W-1:0] w_retired,
    output logic [15:0]      w_flushes
);

    // Drain counter only needs to hold DRAIN_CYCLES down to 1.
    localparam int             DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]  DRAIN_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   drain_reg, drain_next;
    logic            v1_reg, v1_next;
    logic            v2_reg, v2_next;
    logic            flush_inc;
    logic            taken;
    logic            halt;
    logic [CNT_W-1:0] cycles_reg;
    logic [CNT_W-1:0] retired_reg;
    logic [15:0]     flushes_reg;

    // A branch only redirects if it is a real instruction in EX; a halt only
    // counts if it is a real instruction in ID.
    assign taken = w_ex_taken & v2_reg;
    assign halt  = w_id_halt & v1_reg;

    // Next-state and pipeline control: taken branch beats halt beats stall.
    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        w_pc_we    = 1'b0;
        w_p1_we    = 1'b0;
        w_p1_flush = 1'b1;
        w_p2_flush = 1'b1;
        flush_inc  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (w_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (taken) begin
                    // Redirect PC; kill wrong-path instructions in P1 and EX.
                    w_pc_we   = 1'b1;
                    flush_inc = 1'b1;
                end else if (halt) begin
                    // Let the halt itself move into P2, stop fetching.
                    w_p2_flush = 1'b0;
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (w_stall_req) begin
                    // Hold PC and P1, feed a bubble into P2.
                    w_p1_flush = 1'b0;
                end else begin
                    w_pc_we    = 1'b1;
                    w_p1_we    = 1'b1;
                    w_p1_flush = 1'b0;
                    w_p2_flush = 1'b0;
                end
            end
            ST_DRAIN: begin
                drain_next = drain_reg - DRAIN_ONE;
                if (drain_reg == DRAIN_ONE) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Valid bits follow the flush/load decisions made above.
    always_comb begin
        v1_next = v1_reg;
        if (w_p1_flush) begin
            v1_next = 1'b0;
        end else if (w_p1_we) begin
            v1_next = 1'b1;
        end
        v2_next = w_p2_flush ? 1'b0 : v1_reg;
    end

    // FSM, drain counter and valid-bit registers.
    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_reg <= ST_IDLE;
            drain_reg <= '0;
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            v1_reg    <= v1_next;
            v2_reg    <= v2_next;
        end
    end

    // Performance counters: active cycles, retirements, saturating flush count.
    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cycles_reg  <= '0;
            retired_reg <= '0;
            flushes_reg <= '0;
        end else begin
            if ((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) begin
                cycles_reg <= cycles_reg + CNT_ONE;
            end
            if (v2_reg) begin
                retired_reg <= retired_reg + CNT_ONE;
            end
            if (flush_inc && (flushes_reg != 16'hFFFF)) begin
                flushes_reg <= flushes_reg + 16'd1;
            end
        end
    end

    // EX->ID bypass, one comparator per ID source operand; rs1 is always read.
    logic [4:0] id_rs [2];
    logic [1:0] id_use;
    logic [1:0] fwd;

    assign id_rs[0]  = w_id_rs1;
    assign id_rs[1]  = w_id_rs2;
    assign id_use[0] = 1'b1;
    assign id_use[1] = w_id_use_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = v2_reg & w_ex_wen & (w_ex_rd != 5'd0)
                           & (w_ex_rd == id_rs[gi]) & id_use[gi];
        end
    endgenerate

    assign w_fwd1    = fwd[0];
    assign w_fwd2    = fwd[1];
    assign w_running = (state_reg == ST_RUN);
    assign w_done    = (state_reg == ST_HALTED);
    assign w_cycles  = cycles_reg;
    assign w_retired = retired_reg;
    assign w_flushes = flushes_reg;

endmodule

// File: tb/tb_m_pipe_ctrl.sv
// tb_m_pipe_ctrl: random-program bench; the bench plays the datapath, tracks
// which program instruction sits in each stage, and checks the controller
// cycle by cycle against that instruction-level model.
module tb_m_pipe_ctrl;

    localparam int DRAIN_CYCLES = 2;
    localparam int CNT_W        = 32;
    localparam int PROG_N       = 256;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic             w_clock;
    logic             w_rst_n;
    logic             w_start;
    logic             w_stall_req;
    logic [4:0]       w_id_rs1;
    logic [4:0]       w_id_rs2;
    logic             w_id_use_rs2;
    logic             w_id_halt;
    logic [4:0]       w_ex_rd;
    logic             w_ex_wen;
    logic             w_ex_taken;
    logic             w_pc_we;
    logic             w_p1_we;
    logic             w_p1_flush;
    logic             w_p2_flush;
    logic             w_fwd1;
    logic             w_fwd2;
    logic             w_running;
    logic             w_done;
    logic [CNT_W-1:0] w_cycles;
    logic [CNT_W-1:0] w_retired;
    logic [15:0]      w_flushes;

    m_pipe_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .w_clock      (w_clock),
        .w_rst_n      (w_rst_n),
        .w_start      (w_start),
        .w_stall_req  (w_stall_req),
        .w_id_rs1     (w_id_rs1),
        .w_id_rs2     (w_id_rs2),
        .w_id_use_rs2 (w_id_use_rs2),
        .w_id_halt    (w_id_halt),
        .w_ex_rd      (w_ex_rd),
        .w_ex_wen     (w_ex_wen),
        .w_ex_taken   (w_ex_taken),
        .w_pc_we      (w_pc_we),
        .w_p1_we      (w_p1_we),
        .w_p1_flush   (w_p1_flush),
        .w_p2_flush   (w_p2_flush),
        .w_fwd1       (w_fwd1),
        .w_fwd2       (w_fwd2),
        .w_running    (w_running),
        .w_done       (w_done),
        .w_cycles     (w_cycles),
        .w_retired    (w_retired),
        .w_flushes    (w_flushes)
    );

    initial w_clock = 1'b0;
    always #5 w_clock = ~w_clock;

    typedef struct {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit         use_rs2;
        bit         halt;
        bit         wen;
        bit         br;
        bit         tk;
        int         tgt;
    } instr_t;

    instr_t prog [PROG_N];

    // Model: mode, which program slot is in P1/P2, fetch PC, and counters.
    int     m_state;
    bit     m_v1, m_v2;
    int     m_i1, m_i2;
    int     m_pc;
    int     m_drain;
    longint m_cycles, m_retired;
    int     m_flushes;

    int total;
    int bad;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_v1      = 1'b0;
        m_v2      = 1'b0;
        m_i1      = 0;
        m_i2      = 0;
        m_pc      = 0;
        m_drain   = 0;
        m_cycles  = 0;
        m_retired = 0;
        m_flushes = 0;
    endtask

    // Assert reset at an arbitrary point inside a cycle and check the
    // asynchronous reset values; inputs are set to provoke fwd/halt/taken.
    task automatic apply_reset(input int delay_ns);
        #(delay_ns);
        w_rst_n      = 1'b0;
        w_start      = 1'b1;
        w_stall_req  = 1'b0;
        w_id_rs1     = 5'd5;
        w_id_rs2     = 5'd5;
        w_id_use_rs2 = 1'b1;
        w_id_halt    = 1'b1;
        w_ex_rd      = 5'd5;
        w_ex_wen     = 1'b1;
        w_ex_taken   = 1'b1;
        #1;
        check_eq("rst_pc_we",    64'(w_pc_we),    64'd0);
        check_eq("rst_p1_we",    64'(w_p1_we),    64'd0);
        check_eq("rst_p1_flush", 64'(w_p1_flush), 64'd1);
        check_eq("rst_p2_flush", 64'(w_p2_flush), 64'd1);
        check_eq("rst_fwd1",     64'(w_fwd1),     64'd0);
        check_eq("rst_fwd2",     64'(w_fwd2),     64'd0);
        check_eq("rst_running",  64'(w_running),  64'd0);
        check_eq("rst_done",     64'(w_done),     64'd0);
        check_eq("rst_cycles",   64'(w_cycles),   64'd0);
        check_eq("rst_retired",  64'(w_retired),  64'd0);
        check_eq("rst_flushes",  64'(w_flushes),  64'd0);
        model_reset();
        @(negedge w_clock);
        w_rst_n = 1'b1;
        w_start = 1'b0;
    endtask

    // One clock cycle: drive ID/EX fields from the model's stage contents,
    // check the controller, then advance the model at the clock edge.
    task automatic step(input bit start, input bit stall);
        bit e_pc_we, e_p1_we, e_p1f, e_p2f, e_f1, e_f2, chk_p1we, tk, hl;
        int ev;
        w_start     = start;
        w_stall_req = stall;
        if (m_v1) begin
            w_id_rs1     = prog[m_i1].rs1;
            w_id_rs2     = prog[m_i1].rs2;
            w_id_use_rs2 = prog[m_i1].use_rs2;
            w_id_halt    = prog[m_i1].halt;
        end else begin
            w_id_rs1     = 5'($urandom_range(0, 7));
            w_id_rs2     = 5'($urandom_range(0, 7));
            w_id_use_rs2 = 1'($urandom_range(0, 1));
            w_id_halt    = 1'($urandom_range(0, 1));
        end
        if (m_v2) begin
            w_ex_rd    = prog[m_i2].rd;
            w_ex_wen   = prog[m_i2].wen;
            w_ex_taken = prog[m_i2].br & prog[m_i2].tk;
        end else begin
            w_ex_rd    = 5'($urandom_range(0, 7));
            w_ex_wen   = 1'($urandom_range(0, 1));
            w_ex_taken = 1'($urandom_range(0, 1));
        end
        #1;
        tk = w_ex_taken && m_v2;
        hl = w_id_halt && m_v1;
        e_pc_we  = 1'b0;
        e_p1_we  = 1'b0;
        e_p1f    = 1'b1;
        e_p2f    = 1'b1;
        chk_p1we = 1'b1;
        ev       = 0;
        if (m_state == M_RUN) begin
            if (tk) begin
                ev = 1; e_pc_we = 1'b1; chk_p1we = 1'b0;
            end else if (hl) begin
                ev = 2; e_p2f = 1'b0; chk_p1we = 1'b0;
            end else if (stall) begin
                ev = 3; e_p1f = 1'b0;
            end else begin
                ev = 4; e_pc_we = 1'b1; e_p1_we = 1'b1; e_p1f = 1'b0; e_p2f = 1'b0;
            end
        end
        e_f1 = m_v2 && w_ex_wen && (w_ex_rd != 5'd0) && (w_ex_rd == w_id_rs1);
        e_f2 = m_v2 && w_ex_wen && (w_ex_rd != 5'd0) && (w_ex_rd == w_id_rs2) && w_id_use_rs2;

        check_eq("pc_we",    64'(w_pc_we),    64'(e_pc_we));
        if (chk_p1we) check_eq("p1_we", 64'(w_p1_we), 64'(e_p1_we));
        check_eq("p1_flush", 64'(w_p1_flush), 64'(e_p1f));
        check_eq("p2_flush", 64'(w_p2_flush), 64'(e_p2f));
        check_eq("fwd1",     64'(w_fwd1),     64'(e_f1));
        check_eq("fwd2",     64'(w_fwd2),     64'(e_f2));
        check_eq("running",  64'(w_running),  64'(m_state == M_RUN));
        check_eq("done",     64'(w_done),     64'(m_state == M_HALTED));
        check_eq("cycles",   64'(w_cycles),   64'(m_cycles));
        check_eq("retired",  64'(w_retired),  64'(m_retired));
        check_eq("flushes",  64'(w_flushes),  64'(m_flushes));

        @(posedge w_clock);
        if (m_v2) m_retired++;
        if (m_state == M_RUN || m_state == M_DRAIN) m_cycles++;
        case (m_state)
            M_IDLE: begin
                m_v1 = 1'b0; m_v2 = 1'b0;
                if (start) m_state = M_RUN;
            end
            M_RUN: begin
                case (ev)
                    1: begin
                        m_pc = prog[m_i2].tgt;
                        m_v1 = 1'b0; m_v2 = 1'b0;
                        if (m_flushes < 65535) m_flushes++;
                    end
                    2: begin
                        m_i2 = m_i1; m_v2 = 1'b1; m_v1 = 1'b0;
                        m_state = M_DRAIN;
                        m_drain = DRAIN_CYCLES;
                    end
                    3: begin
                        m_v2 = 1'b0;
                    end
                    default: begin
                        m_i2 = m_i1; m_v2 = m_v1;
                        m_i1 = m_pc; m_v1 = 1'b1;
                        m_pc = (m_pc + 1) % PROG_N;
                    end
                endcase
            end
            M_DRAIN: begin
                m_v1 = 1'b0; m_v2 = 1'b0;
                if (m_drain == 1) m_state = M_HALTED;
                else m_drain--;
            end
            default: begin
                m_v1 = 1'b0; m_v2 = 1'b0;
            end
        endcase
        @(negedge w_clock);
    endtask

    task automatic gen_program(input bit directed);
        int r;
        for (int i = 0; i < PROG_N; i++) begin
            prog[i].rd      = 5'($urandom_range(0, 7));
            prog[i].rs1     = 5'($urandom_range(0, 7));
            prog[i].rs2     = 5'($urandom_range(0, 7));
            prog[i].use_rs2 = 1'($urandom_range(0, 1));
            prog[i].halt    = 1'b0;
            prog[i].wen     = 1'b1;
            prog[i].br      = 1'b0;
            prog[i].tk      = 1'b0;
            prog[i].tgt     = 0;
            r = int'($urandom_range(0, 99));
            if (!directed) begin
                if (r < 3 || (i % 40) == 39) begin
                    prog[i].halt = 1'b1; prog[i].rd = 5'd30;
                end else if (r < 20) begin
                    prog[i].br  = 1'b1; prog[i].wen = 1'b0;
                    prog[i].tk  = 1'($urandom_range(0, 1));
                    prog[i].tgt = (i + int'($urandom_range(2, 9))) % PROG_N;
                end else if (r < 28) begin
                    prog[i].wen = 1'b0;
                end
            end
        end
        if (directed) begin
            // addi x5,x0,7 ; add x6,x5,x5 ; addi x0,.. ; add x7,x0,x0
            prog[0].rd = 5'd5; prog[0].rs1 = 5'd0;
            prog[1].rd = 5'd6; prog[1].rs1 = 5'd5; prog[1].rs2 = 5'd5; prog[1].use_rs2 = 1'b1;
            prog[2].rd = 5'd0;
            prog[3].rd = 5'd7; prog[3].rs1 = 5'd0; prog[3].rs2 = 5'd0; prog[3].use_rs2 = 1'b1;
            // taken bne with a wrong-path halt behind it
            prog[4].br = 1'b1; prog[4].tk = 1'b1; prog[4].wen = 1'b0; prog[4].tgt = 10;
            prog[5].halt = 1'b1; prog[5].rd = 5'd30;
            prog[15].halt = 1'b1; prog[15].rd = 5'd30;
        end
    endtask

    task automatic episode(input int ep, input bit directed, input bit rst_in_drain);
        int  stall_left;
        int  halted_cnt;
        bit  stall;
        bit  did_reset;
        gen_program(directed);
        apply_reset(0);
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        stall_left = 0;
        halted_cnt = 0;
        did_reset  = 1'b0;
        for (int n = 0; n < 400 && halted_cnt < 4; n++) begin
            if (rst_in_drain && m_state == M_DRAIN) begin
                $display("episode %0d: reset in drain, retired=%0d", ep, m_retired);
                apply_reset(2);
                did_reset = 1'b1;
                break;
            end
            stall = 1'b0;
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else if (int'($urandom_range(0, 99)) < (directed ? 0 : 6)) begin
                stall_left = int'($urandom_range(0, 3));
                stall = 1'b1;
            end
            step(1'($urandom_range(0, 99) < 5), stall);
            if (m_state == M_HALTED) halted_cnt++;
        end
        if (!did_reset) begin
            check_eq("end_done", 64'(w_done), 64'd1);
            $display("episode %0d: cycles=%0d retired=%0d flushes=%0d",
                     ep, m_cycles, m_retired, m_flushes);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        w_rst_n      = 1'b0;
        w_start      = 1'b0;
        w_stall_req  = 1'b0;
        w_id_rs1     = '0;
        w_id_rs2     = '0;
        w_id_use_rs2 = 1'b0;
        w_id_halt    = 1'b0;
        w_ex_rd      = '0;
        w_ex_wen     = 1'b0;
        w_ex_taken   = 1'b0;
        model_reset();
        @(negedge w_clock);
        episode(0, 1'b1, 1'b0);
        for (int ep = 1; ep < 9; ep++) begin
            episode(ep, 1'b0, (ep % 3) == 2);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
